// File: rtl/manchester_pkg.sv
// Shared byte-level framing constants and deframer state encoding for the
// manchester framer/escaper/preamble/deframer family.
package manchester_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] PRE     = 8'h55;
    localparam logic [BYTE_W-1:0] SOF     = 8'h7E;
    localparam logic [BYTE_W-1:0] EOF     = 8'h7F;
    localparam logic [BYTE_W-1:0] ESC     = 8'h7D;
    localparam logic [BYTE_W-1:0] ESC_XOR = 8'h20;

    localparam int unsigned ST_W = 2;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_HUNT = 2'd0;
    localparam state_t ST_DATA = 2'd1;
    localparam state_t ST_ESC  = 2'd2;

endpackage

// File: rtl/manchester_deframer.sv
// Receive deframer: hunts for SOF, un-escapes payload, strips EOF and emits
// AXI-Stream beats with tlast on the true last byte via a one-byte hold register.
module manchester_deframer
    import manchester_pkg::*;
#(
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned LEN_W   = 9
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [BYTE_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [BYTE_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              frame_ok,
    output logic              frame_err
);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BYTE_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              tuser_q, tuser_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;

    logic              in_fire, out_fire;
    logic              is_sof, is_eof, is_esc, len_full;
    logic              pay_v, close_v, close_user, restart;
    logic [BYTE_W-1:0] pay_b;

    // Input may only be taken when the output register is free this cycle.
    assign s_axis_tready = !tvalid_q || m_axis_tready;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = tvalid_q && m_axis_tready;
    assign is_sof        = (s_axis_tdata == SOF);
    assign is_eof        = (s_axis_tdata == EOF);
    assign is_esc        = (s_axis_tdata == ESC);
    assign len_full      = (len_q == LEN_W'(MAX_LEN));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_fire) begin
            case (state_q)
                ST_HUNT: if (is_sof) state_d = ST_DATA;
                ST_DATA: begin
                    if (is_esc)                  state_d = ST_ESC;
                    else if (is_eof)             state_d = ST_HUNT;
                    else if (!is_sof && len_full) state_d = ST_HUNT;
                end
                ST_ESC: begin
                    if (is_sof)        state_d = ST_DATA;
                    else if (is_eof)   state_d = ST_HUNT;
                    else if (len_full) state_d = ST_HUNT;
                    else               state_d = ST_DATA;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Classify the consumed byte, then drive hold, length and output register.
    always_comb begin
        pay_v        = 1'b0;
        pay_b        = s_axis_tdata;
        close_v      = 1'b0;
        close_user   = 1'b0;
        restart      = 1'b0;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        len_d        = len_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q && !m_axis_tready;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        frame_err_d  = 1'b0;

        if (in_fire) begin
            case (state_q)
                ST_HUNT: restart = is_sof;
                ST_DATA: begin
                    if (is_esc) begin
                        pay_v = 1'b0;
                    end else if (is_eof) begin
                        close_v = 1'b1;
                    end else if (is_sof) begin
                        close_v    = 1'b1;
                        close_user = 1'b1;
                    end else begin
                        pay_v = 1'b1;
                    end
                end
                ST_ESC: begin
                    if (is_sof || is_eof) begin
                        close_v    = 1'b1;
                        close_user = 1'b1;
                    end else begin
                        pay_v = 1'b1;
                        pay_b = s_axis_tdata ^ ESC_XOR;
                    end
                end
                default: restart = 1'b0;
            endcase
        end

        if (pay_v && len_full) begin
            pay_v      = 1'b0;
            close_v    = 1'b1;
            close_user = 1'b1;
        end

        // An SOF abort with nothing held is a silent restart, not an error.
        frame_err_d = close_user && (hold_valid_q || !is_sof);

        if (restart || close_v) begin
            hold_valid_d = 1'b0;
            len_d        = '0;
        end
        if (close_v && hold_valid_q) begin
            tvalid_d = 1'b1;
            tdata_d  = hold_q;
            tlast_d  = 1'b1;
            tuser_d  = close_user;
        end
        if (pay_v) begin
            if (hold_valid_q) begin
                tvalid_d = 1'b1;
                tdata_d  = hold_q;
                tlast_d  = 1'b0;
                tuser_d  = 1'b0;
            end
            hold_d       = pay_b;
            hold_valid_d = 1'b1;
            len_d        = len_q + LEN_W'(1);
        end

        frame_ok_d = out_fire && tlast_q && !tuser_q && !frame_err_d;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            len_q        <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            len_q        <= len_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frame_ok      = frame_ok_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_manchester_deframer.sv
// Directed bench for manchester_deframer: two instances (MAX_LEN 256 and 4)
// share one driver/monitor selected by sel4.
module tb_manchester_deframer;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       m_tready;
    logic       sel4;
    logic       rnd_en;

    logic [7:0] a_tdata, b_tdata;
    logic       a_srdy, a_tvalid, a_tlast, a_tuser, a_ok, a_err;
    logic       b_srdy, b_tvalid, b_tlast, b_tuser, b_ok, b_err;

    always #5 aclk = ~aclk;

    manchester_deframer #(.MAX_LEN(256), .LEN_W(9)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && !sel4), .s_axis_tready(a_srdy),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
        .frame_ok(a_ok), .frame_err(a_err)
    );

    manchester_deframer #(.MAX_LEN(4), .LEN_W(3)) u_dut4 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel4), .s_axis_tready(b_srdy),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
        .frame_ok(b_ok), .frame_err(b_err)
    );

    wire [7:0] m_tdata  = sel4 ? b_tdata  : a_tdata;
    wire       s_rdy    = sel4 ? b_srdy   : a_srdy;
    wire       m_tvalid = sel4 ? b_tvalid : a_tvalid;
    wire       m_tlast  = sel4 ? b_tlast  : a_tlast;
    wire       m_tuser  = sel4 ? b_tuser  : a_tuser;
    wire       f_ok     = sel4 ? b_ok     : a_ok;
    wire       f_err    = sel4 ? b_err    : a_err;

    logic [9:0] got_q[$];
    int         n_ok  = 0;
    int         n_err = 0;

    // Record accepted beats {tuser,tlast,tdata} and pulse counts mid-cycle.
    always @(negedge aclk) begin
        if (m_tvalid && m_tready) got_q.push_back({m_tuser, m_tlast, m_tdata});
        if (f_ok)  n_ok++;
        if (f_err) n_err++;
    end

    always @(posedge aclk) begin
        #1;
        m_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int         n_checks = 0;
    int         n_errors = 0;
    int         base, base_ok, base_err;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int   n;
        logic acc;
        s_tdata  = b;
        s_tvalid = 1'b1;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 1000) begin
            @(negedge aclk);
            acc = s_rdy;
            @(posedge aclk);
            #1;
            n++;
        end
        s_tvalid = 1'b0;
        if (!acc) check("send_tmo", 32'(acc), 32'd1);
    endtask

    task automatic begin_test();
        base     = got_q.size();
        base_ok  = n_ok;
        base_err = n_err;
        exp_q.delete();
    endtask

    task automatic exp_beat(input logic [7:0] d, input logic last, input logic user);
        exp_q.push_back({user, last, d});
    endtask

    task automatic run_check(input string tag, input int ok_e, input int err_e);
        rnd_en = 1'b0;
        repeat (20) @(posedge aclk);
        #1;
        check({tag, "_nbeats"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check($sformatf("%s_beat%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
        end
        check({tag, "_ok"},  32'(n_ok - base_ok),   32'(ok_e));
        check({tag, "_err"}, 32'(n_err - base_err), 32'(err_e));
    endtask

    logic [7:0] pl[200];

    initial begin
        sel4     = 1'b0;
        rnd_en   = 1'b0;
        s_tdata  = 8'h00;
        do_reset();

        // Reset state.
        @(negedge aclk);
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_srdy",   32'(s_rdy),    1);
        check("rst_tlast",  32'(m_tlast),  0);
        check("rst_tuser",  32'(m_tuser),  0);
        check("rst_tdata",  32'(m_tdata),  0);
        check("rst_pulses", 32'({f_ok, f_err}), 0);
        @(posedge aclk);
        #1;

        // 1: preamble discarded, one-byte lookahead latency.
        begin_test();
        send(8'h55); send(8'h55); send(8'h7E); send(8'h01);
        repeat (3) @(posedge aclk);
        #1;
        check("t1_lat0", 32'(got_q.size() - base), 0);
        send(8'h02);
        repeat (3) @(posedge aclk);
        #1;
        check("t1_lat1", 32'(got_q.size() - base), 1);
        send(8'h03); send(8'h7F);
        exp_beat(8'h01, 0, 0); exp_beat(8'h02, 0, 0); exp_beat(8'h03, 1, 0);
        run_check("t1", 1, 0);

        // 2: escapes and PRE as payload.
        begin_test();
        foreach (pl[i]) pl[i] = 8'h00;
        send(8'h7E); send(8'h7D); send(8'h5E); send(8'h7D); send(8'h5D);
        send(8'h7D); send(8'h5F); send(8'h55); send(8'h7F);
        exp_beat(8'h7E, 0, 0); exp_beat(8'h7D, 0, 0); exp_beat(8'h7F, 0, 0); exp_beat(8'h55, 1, 0);
        run_check("t2", 1, 0);

        // 3: SOF abort then resync.
        begin_test();
        send(8'h7E); send(8'h10); send(8'h11); send(8'h7E); send(8'h20); send(8'h7F);
        exp_beat(8'h10, 0, 0); exp_beat(8'h11, 1, 1); exp_beat(8'h20, 1, 0);
        run_check("t3", 1, 1);

        // 4: empty frame, then escaped EOF error with nothing held.
        begin_test();
        send(8'h7E); send(8'h7F);
        run_check("t4a", 0, 0);
        begin_test();
        send(8'h7E); send(8'h7D); send(8'h7F);
        run_check("t4b", 0, 1);

        // 5: overrun with MAX_LEN=4.
        sel4 = 1'b1;
        begin_test();
        send(8'h7E);
        for (int i = 1; i <= 6; i++) send(8'(i));
        send(8'h7F);
        exp_beat(8'h01, 0, 0); exp_beat(8'h02, 0, 0); exp_beat(8'h03, 0, 0); exp_beat(8'h04, 1, 1);
        run_check("t5", 0, 1);
        sel4 = 1'b0;
        @(posedge aclk);
        #1;

        // 6: 200-byte frame under random backpressure, specials escaped.
        begin_test();
        foreach (pl[i]) begin
            case (i % 7)
                0: pl[i] = 8'h7E;
                1: pl[i] = 8'h7D;
                2: pl[i] = 8'h7F;
                default: pl[i] = 8'($urandom_range(0, 255));
            endcase
        end
        rnd_en = 1'b1;
        send(8'h7E);
        foreach (pl[i]) begin
            if (pl[i] == 8'h7E || pl[i] == 8'h7D || pl[i] == 8'h7F) begin
                send(8'h7D);
                send(pl[i] ^ 8'h20);
            end else begin
                send(pl[i]);
            end
            exp_beat(pl[i], (i == 199), 0);
        end
        send(8'h7F);
        run_check("t6", 1, 0);

        // 6b: reset mid-frame, then no beats until the next SOF.
        rnd_en = 1'b1;
        send(8'h7E);
        for (int i = 0; i < 10; i++) send(8'(8'h30 + i));
        rnd_en = 1'b0;
        do_reset();
        begin_test();
        send(8'h01); send(8'h02); send(8'h7F);
        run_check("t6_rst", 0, 0);
        begin_test();
        send(8'h7E); send(8'hAA); send(8'h7F);
        exp_beat(8'hAA, 1, 0);
        run_check("t6_resync", 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
